fu_rr_arbiter: RTL
==================

Name: fu_rr_arbiter

Overview:
- Shares one 8-bit Functional_Unit (3-bit instruction, operands A/B, result F) between NUM_REQ requesters using round-robin arbitration.
- Each cycle it grants at most one requester and steers that requester's instruction and operands onto the FU inputs.
- It captures F into a one-entry response register, tagged with the requester id, with valid/ready backpressure.
- Sits between requester blocks (find_MAX-style scanners and similar clients) and a single shared Functional_Unit instance.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..8.
- W, 8, operand/result width; must match the FU.
- IDW, 2, requester id width; equals log2(NUM_REQ).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- req_instr  input  3*NUM_REQ  packed instructions; requester i at bits [3i+2:3i].
- req_a  input  W*NUM_REQ  packed operand A; requester i at [W*i+W-1:W*i].
- req_b  input  W*NUM_REQ  packed operand B, same packing.
- gnt  output  NUM_REQ  one-hot grant, combinational, valid in the same cycle.
- fu_instruction  output  3  to FU instruction.
- fu_a  output  W  to FU A.
- fu_b  output  W  to FU B.
- fu_f  input  W  from FU F; combinational result of fu_* in the same cycle.
- rsp_valid  output  1  response register holds a result.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_data  output  W  captured FU result.
- rsp_ready  input  1  consumer accepts the response this cycle.

Behaviour:
- Reset: rst is sampled on clk rising edge.
  - Next cycle: rsp_valid=0, rsp_id=0, rsp_data=0, rr pointer ptr=0.
  - While rst=1, gnt=0 and fu_* are driven 0, regardless of req.
- Slot free: slot_free = !rsp_valid || rsp_ready.
- Grant: when slot_free && |req && !rst, gnt = one-hot of the first set req bit searching ptr, ptr+1, ..., wrapping mod NUM_REQ. Otherwise gnt=0.
- FU steering:
  - With a grant: fu_instruction/fu_a/fu_b = the granted requester's fields.
  - With no grant: all fu_* = 0.
- Capture: on an edge where a grant is given, rsp_valid<=1, rsp_id<=granted index, rsp_data<=fu_f, ptr<=(granted index+1) mod NUM_REQ.
- Drain: on an edge with rsp_valid && rsp_ready and no grant, rsp_valid<=0. rsp_id and rsp_data hold their last values.
- Stall: while rsp_valid && !rsp_ready, gnt=0, the response register holds, and ptr holds.
- Simultaneous drain and grant (rsp_ready=1 with a new grant): the register is overwritten with the new result, rsp_valid stays 1, and there is no bubble. Full throughput is 1 op/cycle.
- Latency: request granted in cycle N gives rsp_valid in cycle N+1.
- Requester protocol:
  - Hold req and operands stable until gnt is seen.
  - A gnt pulse consumes exactly one operation.
  - req still high in the cycle after gnt is a new operation.
- ptr advances only on a grant, never on idle cycles.
- No starvation: with req held high, a requester is granted within NUM_REQ grants.
- Result width: rsp_data is exactly W bits of fu_f. Carries and overflow are discarded by the FU, and the arbiter adds no extension.
- Reset mid-operation: an unconsumed response is dropped (rsp_valid=0 next cycle). No grant is issued in the reset cycle.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=4'b1111 and rsp_ready=1 -> gnt=0 and fu_*=0 throughout; after release rsp_valid=0, rsp_data=0, rsp_id=0.
2. Single op: req=4'b0001, instr0=3'b000, A0=8'h10, B0=8'h05, in cycle N -> gnt=4'b0001 in N; in N+1 rsp_valid=1, rsp_id=0, rsp_data=8'h15.
3. Round robin: req=4'b1111 held, rsp_ready=1, requester i has instr=3'b011, A=i, B=8'hF0 -> grants 0,1,2,3,0 on consecutive cycles; rsp_data=8'hF0,F1,F2,F3,F0 back-to-back with no gaps.
4. Backpressure: response pending, rsp_ready=0 for 3 cycles with req=4'b0010 -> gnt=0 and rsp_data/rsp_id held. In the cycle rsp_ready returns to 1, gnt=4'b0010 and the register is overwritten on the next edge.
5. Wrap and skip: after a grant to requester 1 (ptr=2), req=4'b1001 -> grant 3 first, then 0. Then req=4'b0001 only -> grant 0 on every cycle.
6. Reset mid-op: rsp_valid=1, rsp_ready=0, ptr=3, assert rst for 1 cycle -> rsp_valid=0 next cycle; then req=4'b1111 -> first grant is requester 0.

Source files
------------

// File: rtl/fu_rr_arbiter.sv
// rtl/fu_rr_arbiter.sv - round-robin arbiter sharing one Functional_Unit between NUM_REQ requesters
//
// Purpose: each cycle grants at most one requester (round-robin from r_ptr),
// steers its instruction/operands onto the shared FU, and captures the FU
// result into a one-entry tagged response register with valid/ready handshake.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req[NUM_REQ]                  per-requester request level
//   req_instr/req_a/req_b         packed per-requester instruction and operands
//   gnt[NUM_REQ]                  combinational one-hot grant
//   fu_instruction/fu_a/fu_b      drive the shared FU
//   fu_f                          combinational FU result
//   rsp_valid/rsp_id/rsp_data     response register
//   rsp_ready                     consumer accepts the response

module fu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 8,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [3*NUM_REQ-1:0] req_instr,
    input  logic [W*NUM_REQ-1:0] req_a,
    input  logic [W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [2:0]           fu_instruction,
    output logic [W-1:0]         fu_a,
    output logic [W-1:0]         fu_b,
    input  logic [W-1:0]         fu_f,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_data,
    input  logic                 rsp_ready
);

    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [W-1:0]       r_rsp_data;
    logic [IDW-1:0]     r_ptr;

    logic               w_slot_free;
    logic               w_found;
    logic [IDW-1:0]     w_gnt_idx;
    logic [IDW-1:0]     w_scan_idx;

    // A pending response blocks new grants unless it is drained this cycle.
    assign w_slot_free = !r_rsp_valid || rsp_ready;

    // Scan ptr, ptr+1, ... ; IDW-bit addition wraps mod NUM_REQ since NUM_REQ is a power of two.
    always_comb begin
        w_found    = 1'b0;
        w_gnt_idx  = '0;
        w_scan_idx = '0;
        if (!rst && w_slot_free) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_scan_idx = r_ptr + IDW'(k);
                if (!w_found && req[w_scan_idx]) begin
                    w_found   = 1'b1;
                    w_gnt_idx = w_scan_idx;
                end
            end
        end
    end

    always_comb begin
        gnt            = '0;
        fu_instruction = '0;
        fu_a           = '0;
        fu_b           = '0;
        if (w_found) begin
            gnt[w_gnt_idx] = 1'b1;
            fu_instruction = req_instr[3*w_gnt_idx +: 3];
            fu_a           = req_a[W*w_gnt_idx +: W];
            fu_b           = req_b[W*w_gnt_idx +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_ptr       <= '0;
        end else if (w_found) begin
            // Grant overwrites the slot even when draining in the same cycle: no bubble.
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_gnt_idx;
            r_rsp_data  <= fu_f;
            r_ptr       <= w_gnt_idx + IDW'(1);
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

endmodule
